// File: rtl/rv32_pkg.sv
// Shared RV32 core constants: data width, architectural register count and
// register address width, used by the register file, decode and writeback mux.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set by load issue,
// cleared by writeback, wiped by flush, with a stall query for two addresses.
module rf_scoreboard
    import rv32_pkg::*;
#(
    parameter int NREGS = rv32_pkg::NREGS
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      set_en_i,
    input  reg_addr_t set_addr_i,
    input  logic      clr_en_i,
    input  reg_addr_t clr_addr_i,
    input  logic      flush_i,
    input  reg_addr_t q1_addr_i,
    input  reg_addr_t q2_addr_i,
    output logic      busy1_o,
    output logic      busy2_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a reissued load to the register being
    // written back keeps it reserved; flush overrides everything.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i && (set_addr_i != '0)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A register whose load result arrives this very cycle is readable via bypass.
    assign busy1_o = (q1_addr_i != '0) && busy_q[q1_addr_i]
                     && !(clr_en_i && (clr_addr_i == q1_addr_i));
    assign busy2_o = (q2_addr_i != '0) && busy_q[q2_addr_i]
                     && !(clr_en_i && (clr_addr_i == q2_addr_i));

endmodule

// File: rtl/regfile_rd.sv
// Integer register file with registered two-port operand read, writeback
// bypass and load-use stall driven by the pending-load scoreboard.
module regfile_rd
    import rv32_pkg::*;
#(
    parameter int XLEN  = rv32_pkg::XLEN,
    parameter int NREGS = rv32_pkg::NREGS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  reg_addr_t       wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            rd_en,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    input  logic            ld_issue,
    input  reg_addr_t       ld_rd,
    input  logic            flush,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rd_valid,
    output logic            stall
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            busy1, busy2;
    logic            accept;
    logic            wb_write;

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (ld_issue),
        .set_addr_i (ld_rd),
        .clr_en_i   (wb_en),
        .clr_addr_i (wb_rd),
        .flush_i    (flush),
        .q1_addr_i  (rs1_addr),
        .q2_addr_i  (rs2_addr),
        .busy1_o    (busy1),
        .busy2_o    (busy2)
    );

    assign stall    = rd_en && (busy1 || busy2);
    assign accept   = rd_en && !stall;
    assign wb_write = wb_en && (wb_rd != '0);

    // x0 never enters the bypass path, so a write to x0 cannot leak into a read.
    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_valid_d = accept;
        if (accept) begin
            if (rs1_addr == '0) begin
                rs1_data_d = '0;
            end else if (wb_write && (wb_rd == rs1_addr)) begin
                rs1_data_d = wb_data;
            end else begin
                rs1_data_d = regs_q[rs1_addr];
            end
            if (rs2_addr == '0) begin
                rs2_data_d = '0;
            end else if (wb_write && (wb_rd == rs2_addr)) begin
                rs2_data_d = wb_data;
            end else begin
                rs2_data_d = regs_q[rs2_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wb_write) begin
                regs_q[wb_rd] <= wb_data;
            end
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_rd.sv
// Directed vector bench for regfile_rd: per-cycle input records with
// hand-computed stall and registered-operand expectations, plus a reset sequence.
module tb_regfile_rd;

    typedef struct {
        logic        wbEn;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
        logic        rdEn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ldIssue;
        logic [4:0]  ldRd;
        logic        flush;
        logic        expStall;
        logic        expValid;
        logic [31:0] expRs1;
        logic [31:0] expRs2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbEn;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        rdEn;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic        ldIssue;
    logic [4:0]  ldRd;
    logic        flush;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic        rdValid;
    logic        stall;

    int checkCount = 0;
    int missCount  = 0;
    int vecCount   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    regfile_rd dut (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wbEn),
        .wb_rd    (wbRd),
        .wb_data  (wbData),
        .rd_en    (rdEn),
        .rs1_addr (rs1Addr),
        .rs2_addr (rs2Addr),
        .ld_issue (ldIssue),
        .ld_rd    (ldRd),
        .flush    (flush),
        .rs1_data (rs1Data),
        .rs2_data (rs2Data),
        .rd_valid (rdValid),
        .stall    (stall)
    );

    function automatic vec_t mk(logic we, logic [4:0] wr, logic [31:0] wd,
                                logic re, logic [4:0] a1, logic [4:0] a2,
                                logic li, logic [4:0] lr, logic fl,
                                logic xs, logic xv, logic [31:0] x1, logic [31:0] x2);
        vec_t v;
        v.wbEn = we; v.wbRd = wr; v.wbData = wd;
        v.rdEn = re; v.rs1 = a1; v.rs2 = a2;
        v.ldIssue = li; v.ldRd = lr; v.flush = fl;
        v.expStall = xs; v.expValid = xv; v.expRs1 = x1; v.expRs2 = x2;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, check combinational stall mid-cycle, then
    // check the registered outputs just after the rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        @(negedge clk);
        wbEn = v.wbEn; wbRd = v.wbRd; wbData = v.wbData;
        rdEn = v.rdEn; rs1Addr = v.rs1; rs2Addr = v.rs2;
        ldIssue = v.ldIssue; ldRd = v.ldRd; flush = v.flush;
        vecCount++;
        #1;
        tag = $sformatf("v%0d.stall", idx);
        checkOutput(tag, {31'b0, stall}, {31'b0, v.expStall});
        @(posedge clk);
        #1;
        tag = $sformatf("v%0d.rd_valid", idx);
        checkOutput(tag, {31'b0, rdValid}, {31'b0, v.expValid});
        tag = $sformatf("v%0d.rs1_data", idx);
        checkOutput(tag, rs1Data, v.expRs1);
        tag = $sformatf("v%0d.rs2_data", idx);
        checkOutput(tag, rs2Data, v.expRs2);
    endtask

    initial begin
        //                we wr  wdata         re a1  a2  li lr  fl st vl rs1           rs2
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  0, 0,  0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0,  0,  0, 0,  0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 5,  0,  0, 0,  0, 0, 1, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  0, 0,  0, 0, 0, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1, 7,  32'h12345678, 1, 5,  7,  0, 0,  0, 0, 1, 32'hDEADBEEF, 32'h12345678));
        vecs.push_back(mk(1, 0,  32'hFFFFFFFF, 0, 0,  0,  0, 0,  0, 0, 0, 32'hDEADBEEF, 32'h12345678));
        vecs.push_back(mk(0, 0,  32'h0,        1, 0,  7,  0, 0,  0, 0, 1, 32'h0,        32'h12345678));
        vecs.push_back(mk(1, 0,  32'hAAAAAAAA, 1, 0,  5,  0, 0,  0, 0, 1, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  1, 9,  0, 0, 0, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(0, 0,  32'h0,        1, 9,  0,  0, 0,  0, 1, 0, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(0, 0,  32'h0,        1, 9,  0,  0, 0,  0, 1, 0, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(0, 0,  32'h0,        1, 5,  9,  0, 0,  0, 1, 0, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(1, 9,  32'hCAFEF00D, 1, 9,  5,  0, 0,  0, 0, 1, 32'hCAFEF00D, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0,  32'h0,        1, 9,  0,  0, 0,  0, 0, 1, 32'hCAFEF00D, 32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  1, 3,  0, 0, 0, 32'hCAFEF00D, 32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 3,  0,  0, 0,  0, 1, 0, 32'hCAFEF00D, 32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  0, 0,  1, 0, 0, 32'hCAFEF00D, 32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 3,  9,  0, 0,  0, 0, 1, 32'h0,        32'hCAFEF00D));
        vecs.push_back(mk(1, 4,  32'h11111111, 0, 0,  0,  1, 4,  0, 0, 0, 32'h0,        32'hCAFEF00D));
        vecs.push_back(mk(0, 0,  32'h0,        1, 4,  0,  0, 0,  0, 1, 0, 32'h0,        32'hCAFEF00D));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  1, 6,  1, 0, 0, 32'h0,        32'hCAFEF00D));
        vecs.push_back(mk(0, 0,  32'h0,        1, 4,  6,  0, 0,  0, 0, 1, 32'h11111111, 32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0,  1, 0,  0, 0, 0, 32'h11111111, 32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 0,  0,  0, 0,  0, 0, 1, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 10, 4,  1, 10, 0, 0, 1, 32'h0,        32'h11111111));
        vecs.push_back(mk(0, 0,  32'h0,        0, 10, 10, 0, 0,  0, 0, 0, 32'h0,        32'h11111111));
        vecs.push_back(mk(0, 0,  32'h0,        1, 0,  10, 0, 0,  0, 1, 0, 32'h0,        32'h11111111));
        vecs.push_back(mk(1, 10, 32'h0BADC0DE, 0, 0,  0,  0, 0,  0, 0, 0, 32'h0,        32'h11111111));
        vecs.push_back(mk(0, 0,  32'h0,        1, 10, 10, 0, 0,  0, 0, 1, 32'h0BADC0DE, 32'h0BADC0DE));

        rst = 1'b1;
        wbEn = 1'b0; wbRd = '0; wbData = '0;
        rdEn = 1'b0; rs1Addr = '0; rs2Addr = '0;
        ldIssue = 1'b0; ldRd = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.rd_valid", {31'b0, rdValid}, 32'h0);
        checkOutput("reset.rs1_data", rs1Data, 32'h0);
        checkOutput("reset.rs2_data", rs2Data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Load in flight when reset hits: outputs clear at once, reservation is gone.
        applyStimulus(mk(0, 0, 32'h0, 0, 0, 0, 1, 12, 0, 0, 0, 32'h0BADC0DE, 32'h0BADC0DE), 100);
        @(negedge clk);
        ldIssue = 1'b0; ldRd = '0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst.rd_valid", {31'b0, rdValid}, 32'h0);
        checkOutput("midrst.rs1_data", rs1Data, 32'h0);
        checkOutput("midrst.rs2_data", rs2Data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mk(0, 0, 32'h0, 1, 12, 5, 0, 0, 0, 0, 1, 32'h0, 32'h0), 101);
        applyStimulus(mk(0, 0, 32'h0, 1, 9, 4, 0, 0, 0, 0, 1, 32'h0, 32'h0), 102);
        applyStimulus(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0), 103);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
